// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register decoder: FSM states and command byte fields.
package spi_reg_pkg;

  localparam int REG_ADDR_W   = 6;
  localparam int CMD_RD_BIT   = 7;
  localparam int CMD_HOLD_BIT = 6;
  localparam int CMD_ADDR_MSB = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_READ,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, with one-cycle rise/fall pulses
// derived from the synchronized value.
module sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q    = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_decoder.sv
// Turns SSEL-framed SPI byte streams (command byte, then data) into burst
// register reads/writes with address auto-increment or hold.
module spi_reg_decoder
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ssel_n,
  input  logic              spi_done,
  input  logic [7:0]        spi_byte_rx,
  output logic [7:0]        spi_byte_tx,
  input  logic [7:0]        status_in,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [7:0]        reg_rd_data,
  output logic              reg_wr_en,
  output logic [7:0]        reg_wr_data,
  output logic              frame_active,
  output logic              frame_end,
  output logic              addr_err
);

  logic ssel_sync;
  logic ssel_rise;
  logic ssel_fall;

  sync_edge #(.RESET_VAL(1'b1)) u_ssel_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (ssel_n),
    .q    (ssel_sync),
    .rise (ssel_rise),
    .fall (ssel_fall)
  );

  state_t            state, state_d;
  logic [7:0]        tx_d;
  logic [ADDR_W-1:0] addr_d;
  logic              wr_en_d;
  logic [7:0]        wr_data_d;
  logic              active_d;
  logic              fend_d;
  logic              aerr_d;
  logic              hold_q, hold_d;
  logic              load_pend, load_d;
  logic              adv_pend, adv_d;
  logic [1:0]        boot_cnt, boot_d;

  logic              addr_valid;
  logic [ADDR_W-1:0] next_addr;

  assign addr_valid = int'(reg_addr) < NUM_REGS;
  assign next_addr  = (int'(reg_addr) == NUM_REGS - 1) ? '0 : reg_addr + ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      spi_byte_tx  <= 8'h00;
      reg_addr     <= '0;
      reg_wr_en    <= 1'b0;
      reg_wr_data  <= 8'h00;
      frame_active <= 1'b0;
      frame_end    <= 1'b0;
      addr_err     <= 1'b0;
      hold_q       <= 1'b0;
      load_pend    <= 1'b0;
      adv_pend     <= 1'b0;
      boot_cnt     <= 2'd0;
    end else begin
      state        <= state_d;
      spi_byte_tx  <= tx_d;
      reg_addr     <= addr_d;
      reg_wr_en    <= wr_en_d;
      reg_wr_data  <= wr_data_d;
      frame_active <= active_d;
      frame_end    <= fend_d;
      addr_err     <= aerr_d;
      hold_q       <= hold_d;
      load_pend    <= load_d;
      adv_pend     <= adv_d;
      boot_cnt     <= boot_d;
    end
  end

  // The synchronizer restarts at "deselected" after reset, so its first real
  // sample (boot_cnt==2) decides whether we woke up inside a frame; any fake
  // fall edge from refilling the pipeline is ignored until then.
  always_comb begin
    state_d   = state;
    tx_d      = spi_byte_tx;
    addr_d    = reg_addr;
    wr_en_d   = 1'b0;
    wr_data_d = reg_wr_data;
    active_d  = frame_active;
    fend_d    = 1'b0;
    aerr_d    = 1'b0;
    hold_d    = hold_q;
    load_d    = load_pend;
    adv_d     = 1'b0;
    boot_d    = (boot_cnt == 2'd3) ? boot_cnt : boot_cnt + 2'd1;

    if (state == ST_IDLE) begin
      tx_d = status_in;
    end

    if (boot_cnt != 2'd3) begin
      if (boot_cnt == 2'd2 && !ssel_sync) begin
        state_d = ST_DRAIN;
      end
    end else if (ssel_rise) begin
      state_d  = ST_IDLE;
      active_d = 1'b0;
      fend_d   = 1'b1;
      load_d   = 1'b0;
    end else if (ssel_fall) begin
      state_d  = ST_CMD;
      active_d = 1'b1;
      load_d   = 1'b0;
    end else begin
      case (state)
        ST_CMD: begin
          if (spi_done) begin
            hold_d = spi_byte_rx[CMD_HOLD_BIT];
            addr_d = ADDR_W'(spi_byte_rx[CMD_ADDR_MSB:0]);
            if (spi_byte_rx[CMD_RD_BIT]) begin
              state_d = ST_READ;
              load_d  = 1'b1;
            end else begin
              state_d = ST_WRITE;
            end
          end
        end
        // Address advances one cycle late so it is still stable while reg_wr_en is high.
        ST_WRITE: begin
          if (adv_pend && !hold_q) begin
            addr_d = next_addr;
          end
          if (spi_done) begin
            wr_en_d = addr_valid;
            aerr_d  = !addr_valid;
            if (addr_valid) begin
              wr_data_d = spi_byte_rx;
            end
            tx_d  = spi_byte_rx;
            adv_d = 1'b1;
          end
        end
        ST_READ: begin
          if (load_pend) begin
            tx_d   = addr_valid ? reg_rd_data : 8'h00;
            aerr_d = !addr_valid;
            load_d = 1'b0;
          end
          if (spi_done) begin
            if (!hold_q) begin
              addr_d = next_addr;
            end
            load_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
